render_sched: RTL

- Frame-level scheduler for the 3D pipeline: framebuffer clear, then triangle projection, then drain of the rasterizer FIFO, then buffer swap on vsync.
- Owns the per-frame rotation angle fed to the projection stage.
- Owns the front/back buffer select used by rasterizer and VGA readout.
- Sits between the top-level run control and the clear, projection and raster blocks.

---
 rtl/render_pkg.sv | 40 ++++
 rtl/angle_accum.sv | 48 ++++
 rtl/render_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : render_pkg
// Description : Shared types and constants for the frame scheduler and the
//               projection stage: scheduler state encoding, angle width and
//               the default angle step / wrap values.
// Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

    // Angle format: ANGLE_WI integer bits, ANGLE_WF fractional bits.
    localparam int ANGLE_WI = 4;
    localparam int ANGLE_WF = 8;
    localparam int ANGLE_W  = ANGLE_WI + ANGLE_WF;

    // Per-frame rotation increment and the 2*pi wrap point, in ANGLE_WI.ANGLE_WF.
    localparam logic [ANGLE_W-1:0] ANGLE_STEP_DEF = 12'd16;
    localparam logic [ANGLE_W-1:0] ANGLE_MAX_DEF  = 12'd1608;

    // Frame scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_CLR_REL  = 3'd2,
        ST_PROJ     = 3'd3,
        ST_PROJ_REL = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_WAIT_VS  = 3'd6,
        ST_SWAP     = 3'd7
    } sched_state_t;

    // True while a frame is actively being rendered (a vsync here is a miss).
    function automatic logic is_render_phase(input sched_state_t s);
        return (s == ST_CLEAR)    || (s == ST_CLR_REL) ||
               (s == ST_PROJ)     || (s == ST_PROJ_REL) ||
               (s == ST_DRAIN);
    endfunction

endpackage : render_pkg
`default_nettype wire

// File: rtl/angle_accum.sv
`default_nettype none
// ============================================================================
// Module      : angle_accum
// Description : Modular fixed-point angle accumulator. On each enable pulse
//               (unless held) adds STEP and wraps at MAX. The sum is formed
//               one bit wider so the comparison never sees an overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module angle_accum
    import render_pkg::*;
#(
    parameter int           W    = ANGLE_W,
    parameter logic [W-1:0] STEP = ANGLE_STEP_DEF,
    parameter logic [W-1:0] MAX  = ANGLE_MAX_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         hold_i,
    output logic [W-1:0] angle_o
);

    localparam logic [W:0] C_STEP_EXT = {1'b0, STEP};
    localparam logic [W:0] C_MAX_EXT  = {1'b0, MAX};

    logic [W-1:0] angle_q;
    logic [W-1:0] angle_d;
    logic [W:0]   w_sum;

    // Next angle: widened add, then subtract the wrap point if reached.
    always_comb begin
        w_sum   = {1'b0, angle_q} + C_STEP_EXT;
        angle_d = (w_sum >= C_MAX_EXT) ? W'(w_sum - C_MAX_EXT) : w_sum[W-1:0];
    end

    // Angle register, advanced only on an un-held enable pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            angle_q <= '0;
        end else if (en_i && !hold_i) begin
            angle_q <= angle_d;
        end
    end

    assign angle_o = angle_q;

endmodule : angle_accum
`default_nettype wire

// File: rtl/render_sched.sv
`default_nettype none
// ============================================================================
// Module      : render_sched
// Description : Frame-level scheduler for the 3D pipeline. Sequences
//               framebuffer clear, triangle projection and rasterizer drain,
//               then swaps buffers on vsync. Owns the per-frame rotation
//               angle, the back-buffer select, frame and missed-vsync counts.
//               Optional phase watchdog: define RENDER_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module render_sched
    import render_pkg::*;
#(
    parameter int                     WIIA       = ANGLE_WI,
    parameter int                     WIFA       = ANGLE_WF,
    parameter logic [WIIA+WIFA-1:0]   ANGLE_STEP = ANGLE_STEP_DEF,
    parameter logic [WIIA+WIFA-1:0]   ANGLE_MAX  = ANGLE_MAX_DEF
`ifdef RENDER_WATCHDOG_EN
    ,
    parameter logic [23:0]            WDOG_CYCLES = 24'd2000000
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      run,
    input  logic                      hold_angle,
    input  logic                      vsync,
    output logic                      clear_start,
    input  logic                      clear_done,
    output logic                      proj_start,
    input  logic                      proj_done,
    input  logic                      fifo_empty,
    input  logic                      draw_idle,
    output logic [WIIA+WIFA-1:0]      angle,
    output logic                      buf_sel,
    output logic [15:0]               frame_count,
    output logic [7:0]                miss_count,
`ifdef RENDER_WATCHDOG_EN
    output logic                      wdog_trip,
`endif
    output logic                      busy
);

    sched_state_t state_q;
    sched_state_t state_d;

    logic        vsync_q;
    logic        w_vsync_rise;
    logic        clear_start_q;
    logic        proj_start_q;
    logic        busy_q;
    logic        buf_sel_q;
    logic [15:0] frame_count_q;
    logic [7:0]  miss_count_q;
    logic        w_swap;
    logic        w_wdog_hit;

    assign w_vsync_rise = vsync & ~vsync_q;
    assign w_swap       = (state_q == ST_SWAP);

`ifdef RENDER_WATCHDOG_EN
    logic [23:0] phase_q;
    logic        wdog_trip_q;

    assign w_wdog_hit = is_render_phase(state_q) && (phase_q == (WDOG_CYCLES - 24'd1));

    // Phase timer restarts on every state change; trip flag is sticky.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            phase_q     <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            phase_q     <= (state_d != state_q) ? 24'd0 : phase_q + 24'd1;
            wdog_trip_q <= wdog_trip_q | w_wdog_hit;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    assign w_wdog_hit = 1'b0;
`endif

    // Next-state decode; a watchdog hit abandons the phase and waits for vsync.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (run && w_vsync_rise)      state_d = ST_CLEAR;
            ST_CLEAR:    if (clear_done)               state_d = ST_CLR_REL;
            ST_CLR_REL:  if (!clear_done)              state_d = ST_PROJ;
            ST_PROJ:     if (proj_done)                state_d = ST_PROJ_REL;
            ST_PROJ_REL: if (!proj_done)               state_d = ST_DRAIN;
            ST_DRAIN:    if (fifo_empty && draw_idle)  state_d = ST_WAIT_VS;
            ST_WAIT_VS:  if (w_vsync_rise)             state_d = ST_SWAP;
            ST_SWAP:     state_d = run ? ST_CLEAR : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (w_wdog_hit) begin
            state_d = ST_WAIT_VS;
        end
    end

    // State register with registered handshake requests and busy flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            clear_start_q <= 1'b0;
            proj_start_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            clear_start_q <= (state_d == ST_CLEAR);
            proj_start_q  <= (state_d == ST_PROJ);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    // Per-frame buffer select and frame counter, updated only on SWAP.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            buf_sel_q     <= 1'b0;
            frame_count_q <= '0;
        end else if (w_swap) begin
            buf_sel_q     <= ~buf_sel_q;
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    // Saturating count of vsync edges that arrive while a frame is still rendering.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            miss_count_q <= '0;
        end else if (w_vsync_rise && is_render_phase(state_q) && (miss_count_q != 8'hFF)) begin
            miss_count_q <= miss_count_q + 8'd1;
        end
    end

    angle_accum #(
        .W    (WIIA + WIFA),
        .STEP (ANGLE_STEP),
        .MAX  (ANGLE_MAX)
    ) u_angle (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .en_i    (w_swap),
        .hold_i  (hold_angle),
        .angle_o (angle)
    );

    assign clear_start = clear_start_q;
    assign proj_start  = proj_start_q;
    assign busy        = busy_q;
    assign buf_sel     = buf_sel_q;
    assign frame_count = frame_count_q;
    assign miss_count  = miss_count_q;

endmodule : render_sched
`default_nettype wire
